// File: rtl/mem_access_stage_pkg.sv
// Constants, state encoding and writeback bundle shared by the memory access stage.
package mem_access_stage_pkg;

  localparam int unsigned XLEN       = 16;
  localparam int unsigned REG_IDX_W  = 3;
  localparam int unsigned REG_SRC_W  = 2;
  localparam int unsigned WAIT_CNT_W = 8;

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_DEFAULT = 8'd200;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Fields carried unchanged from execute to writeback; read data is kept separately.
  typedef struct packed {
    logic [REG_SRC_W-1:0] reg_src;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      alu_out;
    logic [XLEN-1:0]      spec_ops;
    logic                 reg_write;
    logic [REG_IDX_W-1:0] write_reg;
  } wb_fields_t;

  function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
    return mem_read | mem_write;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// Writeback register bundle: pass-through fields and load data with independent load enables.
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  wb_fields_t      d,
  input  logic            ld_read,
  input  logic [XLEN-1:0] rdata,
  output wb_fields_t      q,
  output logic [XLEN-1:0] read_data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= '0;
      read_data <= '0;
    end else begin
      if (ld) begin
        q <= d;
      end
      if (ld_read) begin
        read_data <= rdata;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: issues one data-memory access per load/store and
// hands results to writeback, with a sticky timeout error when memory never answers.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter logic [WAIT_CNT_W-1:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_memRead,
  input  logic                 ex_memWrite,
  input  logic [XLEN-1:0]      ex_aluOut,
  input  logic [XLEN-1:0]      ex_wdata,
  input  logic [XLEN-1:0]      ex_PC,
  input  logic [XLEN-1:0]      ex_specOpsOut,
  input  logic [REG_SRC_W-1:0] ex_regSrc,
  input  logic                 ex_regWrite,
  input  logic [REG_IDX_W-1:0] ex_writeReg,
  input  logic                 flush,
  output logic                 dmem_req,
  output logic                 dmem_wr,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_done,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 wb_valid,
  output logic [REG_SRC_W-1:0] wb_regSrc,
  output logic [XLEN-1:0]      wb_PC,
  output logic [XLEN-1:0]      wb_readData,
  output logic [XLEN-1:0]      wb_aluOut,
  output logic [XLEN-1:0]      wb_specOpsOut,
  output logic                 wb_regWrite,
  output logic [REG_IDX_W-1:0] wb_writeReg,
  output logic                 mem_err
);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt_inc;
  logic                  take;
  logic                  take_mem;
  logic                  access_done;
  wb_fields_t            fields_d;
  wb_fields_t            fields_q;

  assign ex_ready     = (state == IDLE);
  assign take         = ex_valid & ex_ready & ~flush;
  assign take_mem     = take & is_mem_op(ex_memRead, ex_memWrite);
  // Completion is only recognised while a request is outstanding.
  assign access_done  = (state == ACCESS) & dmem_req & dmem_done;
  assign wait_cnt_inc = wait_cnt + 8'd1;

  assign fields_d = '{
    reg_src:   ex_regSrc,
    pc:        ex_PC,
    alu_out:   ex_aluOut,
    spec_ops:  ex_specOpsOut,
    reg_write: ex_regWrite,
    write_reg: ex_writeReg
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_wr    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      mem_err    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take_mem) begin
            // Simultaneous read and write resolves to a store via dmem_wr.
            dmem_req   <= 1'b1;
            dmem_wr    <= ex_memWrite;
            dmem_addr  <= ex_aluOut;
            dmem_wdata <= ex_wdata;
            wait_cnt   <= '0;
            state      <= ACCESS;
          end else if (take) begin
            wb_valid <= 1'b1;
          end
        end
        ACCESS: begin
          if (access_done) begin
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            state    <= IDLE;
          end else if (wait_cnt_inc == TIMEOUT) begin
            mem_err  <= 1'b1;
            dmem_req <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg u_wb_reg (
    .clk       (clk),
    .rst       (rst),
    .ld        (take),
    .d         (fields_d),
    .ld_read   (access_done & ~dmem_wr),
    .rdata     (dmem_rdata),
    .q         (fields_q),
    .read_data (wb_readData)
  );

  assign wb_regSrc     = fields_q.reg_src;
  assign wb_PC         = fields_q.pc;
  assign wb_aluOut     = fields_q.alu_out;
  assign wb_specOpsOut = fields_q.spec_ops;
  assign wb_regWrite   = fields_q.reg_write;
  assign wb_writeReg   = fields_q.write_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a writeback scoreboard.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_ready;
  logic        ex_memRead = 1'b0, ex_memWrite = 1'b0;
  logic [15:0] ex_aluOut = '0, ex_wdata = '0, ex_PC = '0, ex_specOpsOut = '0;
  logic [1:0]  ex_regSrc = '0;
  logic        ex_regWrite = 1'b0;
  logic [2:0]  ex_writeReg = '0;
  logic        flush = 1'b0;
  logic        dmem_req, dmem_wr;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_done = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [1:0]  wb_regSrc;
  logic [15:0] wb_PC, wb_readData, wb_aluOut, wb_specOpsOut;
  logic        wb_regWrite;
  logic [2:0]  wb_writeReg;
  logic        mem_err;

  mem_access_stage #(.TIMEOUT(8'd200)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_aluOut(ex_aluOut),
    .ex_wdata(ex_wdata), .ex_PC(ex_PC), .ex_specOpsOut(ex_specOpsOut),
    .ex_regSrc(ex_regSrc), .ex_regWrite(ex_regWrite), .ex_writeReg(ex_writeReg),
    .flush(flush), .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_done(dmem_done), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_regSrc(wb_regSrc), .wb_PC(wb_PC),
    .wb_readData(wb_readData), .wb_aluOut(wb_aluOut), .wb_specOpsOut(wb_specOpsOut),
    .wb_regWrite(wb_regWrite), .wb_writeReg(wb_writeReg), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  reg_src;
    logic [15:0] pc;
    logic [15:0] read;
    logic [15:0] alu;
    logic [15:0] spec;
    logic        reg_write;
    logic [2:0]  write_reg;
  } wb_t;

  wb_t         exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pulses = 0;
  int unsigned pushes = 0;
  int unsigned ready_low = 0;
  logic [15:0] model_read = '0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1ns later, and retire any writeback against the scoreboard.
  task automatic tick();
    wb_t o;
    wb_t e;
    @(posedge clk);
    #1;
    if (wb_valid === 1'b1) begin
      pulses++;
      chk("wb_pending", 80'(exp_q.size() != 0), 80'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        o = {wb_regSrc, wb_PC, wb_readData, wb_aluOut, wb_specOpsOut, wb_regWrite, wb_writeReg};
        chk("wb_fields", 80'(o), 80'(e));
      end
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic fl,
                       input logic [15:0] alu, input logic [15:0] wd, input logic [15:0] pc,
                       input logic [15:0] spec, input logic [1:0] rs, input logic rw,
                       input logic [2:0] wrg);
    ex_valid = v; ex_memRead = rd; ex_memWrite = wr; flush = fl;
    ex_aluOut = alu; ex_wdata = wd; ex_PC = pc; ex_specOpsOut = spec;
    ex_regSrc = rs; ex_regWrite = rw; ex_writeReg = wrg;
  endtask

  task automatic push(input logic [15:0] alu, input logic [15:0] pc, input logic [15:0] spec,
                      input logic [1:0] rs, input logic rw, input logic [2:0] wrg);
    wb_t e;
    e = '{reg_src: rs, pc: pc, read: model_read, alu: alu, spec: spec,
          reg_write: rw, write_reg: wrg};
    exp_q.push_back(e);
    pushes++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ready", 80'(ex_ready), 80'(1));
    chk("rst_req", 80'({dmem_req, dmem_wr, wb_valid, mem_err}), 80'(0));
    chk("rst_data", 80'({dmem_addr, wb_aluOut, wb_readData, wb_PC}), 80'(0));
    rst = 1'b1;
    tick();

    // Non-memory op, latency 1
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0, 16'h0102, 16'h5555, 2'd2, 1'b1, 3'd3);
    push(16'h1234, 16'h0102, 16'h5555, 2'd2, 1'b1, 3'd3);
    tick();
    chk("alu_wb_valid", 80'(wb_valid), 80'(1));
    chk("alu_no_req", 80'(dmem_req), 80'(0));

    // Back-to-back non-memory ops
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'hA000 + i), 16'h0, 16'(16'h0200 + 2 * i),
            16'(i * 7), 2'(i), 1'(i), 3'(i + 4));
      push(16'(16'hA000 + i), 16'(16'h0200 + 2 * i), 16'(i * 7), 2'(i), 1'(i), 3'(i + 4));
      tick();
      chk("b2b_wb_valid", 80'(wb_valid), 80'(1));
    end
    idle();
    tick();
    chk("b2b_single_pulse", 80'(wb_valid), 80'(0));

    // Load at 0x0040, done after 3 cycles with 0xBEEF
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0, 16'h0300, 16'h0011, 2'd1, 1'b1, 3'd5);
    model_read = 16'hBEEF;
    push(16'h0040, 16'h0300, 16'h0011, 2'd1, 1'b1, 3'd5);
    ready_low = 0;
    tick();
    idle();
    chk("load_req", 80'({dmem_req, dmem_wr, dmem_addr}), 80'({1'b1, 1'b0, 16'h0040}));
    for (int i = 0; i < 3; i++) begin
      if (ex_ready == 1'b0) ready_low++;
      tick();
    end
    chk("load_req_hold", 80'({dmem_req, dmem_wr, dmem_addr}), 80'({1'b1, 1'b0, 16'h0040}));
    if (ex_ready == 1'b0) ready_low++;
    dmem_done = 1'b1; dmem_rdata = 16'hBEEF;
    tick();
    dmem_done = 1'b0; dmem_rdata = 16'h0;
    chk("load_ready_low_cycles", 80'(ready_low), 80'(4));
    chk("load_done", 80'({wb_valid, dmem_req, ex_ready}), 80'({1'b1, 1'b0, 1'b1}));
    tick();
    chk("load_single_pulse", 80'(wb_valid), 80'(0));

    // Store with done already high when request rises
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h00AA, 16'h0400, 16'h0022, 2'd0, 1'b0, 3'd1);
    dmem_done = 1'b1; dmem_rdata = 16'hDEAD;
    push(16'h0010, 16'h0400, 16'h0022, 2'd0, 1'b0, 3'd1);
    tick();
    idle();
    chk("store_req", 80'({dmem_req, dmem_wr, dmem_addr, dmem_wdata}),
        80'({1'b1, 1'b1, 16'h0010, 16'h00AA}));
    chk("store_done_ignored_idle", 80'({wb_valid, ex_ready}), 80'(0));
    tick();
    dmem_done = 1'b0; dmem_rdata = 16'h0;
    chk("store_wb", 80'({wb_valid, wb_readData, dmem_req}), 80'({1'b1, 16'hBEEF, 1'b0}));

    // Flush in IDLE: ALU op and load both discarded
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h0, 16'h0500, 16'h0, 2'd3, 1'b1, 3'd7);
    tick();
    chk("flush_alu", 80'({wb_valid, dmem_req}), 80'(0));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0066, 16'h0, 16'h0502, 16'h0, 2'd1, 1'b1, 3'd2);
    tick();
    idle();
    chk("flush_load", 80'({wb_valid, dmem_req, ex_ready}), 80'({1'b0, 1'b0, 1'b1}));

    // Flush during ACCESS does not affect in-flight load
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0080, 16'h0, 16'h0600, 16'h0033, 2'd1, 1'b1, 3'd6);
    model_read = 16'h1357;
    push(16'h0080, 16'h0600, 16'h0033, 2'd1, 1'b1, 3'd6);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h9999, 16'h0, 16'h0700, 16'h0, 2'd0, 1'b1, 3'd1);
    tick();
    chk("flush_access_hold", 80'({dmem_req, dmem_addr, ex_ready}), 80'({1'b1, 16'h0080, 1'b0}));
    dmem_done = 1'b1; dmem_rdata = 16'h1357;
    tick();
    idle();
    dmem_done = 1'b0;
    chk("flush_access_done", 80'({wb_valid, wb_readData}), 80'({1'b1, 16'h1357}));

    // Read and write both high behaves as a store
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0022, 16'h4444, 16'h0800, 16'h0044, 2'd2, 1'b0, 3'd0);
    push(16'h0022, 16'h0800, 16'h0044, 2'd2, 1'b0, 3'd0);
    tick();
    idle();
    chk("both_is_store", 80'({dmem_req, dmem_wr, dmem_wdata}), 80'({1'b1, 1'b1, 16'h4444}));
    dmem_done = 1'b1; dmem_rdata = 16'hF00D;
    tick();
    dmem_done = 1'b0;
    chk("both_read_held", 80'({wb_valid, wb_readData}), 80'({1'b1, 16'h1357}));

    // Timeout: dmem_done never arrives
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0, 16'h0900, 16'h0, 2'd1, 1'b1, 3'd2);
    tick();
    idle();
    for (int i = 0; i < 199; i++) tick();
    chk("timeout_before", 80'({mem_err, dmem_req, ex_ready}), 80'({1'b0, 1'b1, 1'b0}));
    tick();
    chk("timeout_at", 80'({mem_err, dmem_req, ex_ready, wb_valid}), 80'({1'b1, 1'b0, 1'b1, 1'b0}));
    dmem_done = 1'b1; dmem_rdata = 16'hAAAA;
    tick();
    dmem_done = 1'b0;
    chk("timeout_sticky", 80'({mem_err, wb_valid, wb_readData}), 80'({1'b1, 1'b0, 16'h1357}));

    // Reset in the middle of an access
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0, 16'h0A00, 16'h0055, 2'd1, 1'b1, 3'd4);
    tick();
    idle();
    chk("rst_mid_req", 80'(dmem_req), 80'(1));
    #2 rst = 1'b0;
    #1;
    model_read = '0;
    chk("rst_async_ctrl", 80'({dmem_req, dmem_wr, wb_valid, mem_err, ex_ready}), 80'({4'b0, 1'b1}));
    chk("rst_async_data", 80'({dmem_addr, wb_PC, wb_aluOut, wb_specOpsOut, wb_readData}), 80'(0));
    tick();
    rst = 1'b1;
    dmem_done = 1'b1; dmem_rdata = 16'hCCCC;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0BBB, 16'h0, 16'h0C00, 16'h0066, 2'd0, 1'b1, 3'd7);
    push(16'h0BBB, 16'h0C00, 16'h0066, 2'd0, 1'b1, 3'd7);
    tick();
    idle();
    dmem_done = 1'b0;
    chk("post_rst_accept", 80'({wb_valid, dmem_req, wb_readData}), 80'({1'b1, 1'b0, 16'h0}));
    tick();
    tick();

    chk("scoreboard_empty", 80'(exp_q.size()), 80'(0));
    chk("wb_pulse_count", 80'(pulses), 80'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
